// File: rtl/branch_predict_unit_pkg.sv
// Shared constants and helpers for the branch predictor.
// The counter limits are derived from CNT_W and the index is cut out of the fetch PC.
package branch_predict_unit_pkg;

   localparam int IDX_W_DEF = 6;
   localparam int CNT_W_DEF = 2;
   localparam int PC_W_DEF  = 32;

   localparam int CNT_MIN = 0;

   // Weakly-not-taken: one below the taken threshold (0 for a 1-bit counter).
   function automatic int weak_nt(input int cnt_w);
      return (1 << (cnt_w - 1)) - 1;
   endfunction

   function automatic int cnt_max(input int cnt_w);
      return (1 << cnt_w) - 1;
   endfunction

   localparam int WEAK_NT = weak_nt(CNT_W_DEF);
   localparam int CNT_MAX = cnt_max(CNT_W_DEF);

   // Instructions are word-aligned, so the index starts at PC bit 2.
   function automatic logic [31:0] idx_of(input logic [63:0] pc, input int idx_w);
      logic [63:0] w_mask;
      logic [63:0] w_idx;
      w_mask = (64'd1 << idx_w) - 64'd1;
      w_idx  = (pc >> 2) & w_mask;
      return w_idx[31:0];
   endfunction

endpackage

// File: rtl/sat_counter_table.sv
// Table of saturating counters, with one combinational read port and one clocked
// inc/dec write port. The synchronous reset returns every entry to weakly-not-taken.
module sat_counter_table
   import branch_predict_unit_pkg::*;
#(
   parameter int IDX_W = IDX_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [IDX_W-1:0] i_rd_idx,
   output logic [CNT_W-1:0] o_rd_cnt,
   input  logic             i_wr_en,
   input  logic [IDX_W-1:0] i_wr_idx,
   input  logic             i_wr_up
);

   localparam int DEPTH = 1 << IDX_W;
   localparam logic [CNT_W-1:0] L_WEAK_NT = CNT_W'(weak_nt(CNT_W));
   localparam logic [CNT_W-1:0] L_MAX     = CNT_W'(cnt_max(CNT_W));
   localparam logic [CNT_W-1:0] L_MIN     = CNT_W'(CNT_MIN);

   logic [CNT_W-1:0] r_cnt [DEPTH];
   logic [CNT_W-1:0] w_cur;

   assign o_rd_cnt = r_cnt[i_rd_idx];
   assign w_cur    = r_cnt[i_wr_idx];

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         // NOTE: every entry needs a defined start value, so this array is reset and lands in flops, not RAM.
         for (int i = 0; i < DEPTH; i++) r_cnt[i] <= L_WEAK_NT;
      end else if (i_wr_en) begin
         if (i_wr_up && (w_cur != L_MAX))
            r_cnt[i_wr_idx] <= w_cur + 1'b1;
         else if (!i_wr_up && (w_cur != L_MIN))
            r_cnt[i_wr_idx] <= w_cur - 1'b1;
      end
   end

endmodule

// File: rtl/branch_predict_unit.sv
// PC-indexed saturating-counter branch predictor with fetch->decode->execute tracking.
// Optional BPRED_STATS_EN adds brcount/mispcount statistics outputs.
module branch_predict_unit
   import branch_predict_unit_pkg::*;
#(
   parameter int IDX_W = IDX_W_DEF,
   parameter int CNT_W = CNT_W_DEF,
   parameter int PC_W  = PC_W_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [PC_W-1:0] pcF,
   output logic            predtakenF,
   input  logic            stallD,
   input  logic            flushD,
   input  logic            branchD,
   input  logic            equalD,
   output logic            predtakenD,
   output logic            mispredictD,
   output logic            recovertakenD,
   output logic            branchE,
   output logic            mispredictE
`ifdef BPRED_STATS_EN
   ,
   output logic [31:0]     brcount,
   output logic [31:0]     mispcount
`endif
);

   logic [IDX_W-1:0] w_idxF;
   logic [CNT_W-1:0] w_cntF;
   logic             w_resolveD;
   logic             w_updateD;

   logic             r_validD;
   logic             r_predtakenD;
   logic [IDX_W-1:0] r_idxD;
   logic             r_branchE;
   logic             r_mispredictE;

   assign w_idxF = IDX_W'(idx_of(64'(pcF), IDX_W));

   sat_counter_table #(
      .IDX_W (IDX_W),
      .CNT_W (CNT_W)
   ) u_table (
      .i_clk    (clk),
      .i_reset  (reset),
      .i_rd_idx (w_idxF),
      .o_rd_cnt (w_cntF),
      .i_wr_en  (w_updateD),
      .i_wr_idx (r_idxD),
      .i_wr_up  (equalD)
   );

   assign predtakenF = w_cntF[CNT_W-1];

   // A stalled branch trains only on the cycle it leaves decode.
   assign w_resolveD    = branchD & r_validD;
   assign w_updateD     = w_resolveD & ~stallD;
   assign mispredictD   = w_resolveD & (r_predtakenD ^ equalD);
   assign recovertakenD = equalD;
   assign predtakenD    = r_predtakenD;
   assign branchE       = r_branchE;
   assign mispredictE   = r_mispredictE;

   always_ff @(posedge clk) begin
      if (reset || flushD) begin
         // NOTE: clocked state always uses non-blocking assignments so every flop samples pre-edge values.
         r_validD     <= 1'b0;
         r_predtakenD <= 1'b0;
         r_idxD       <= '0;
      end else if (!stallD) begin
         r_validD     <= 1'b1;
         r_predtakenD <= predtakenF;
         r_idxD       <= w_idxF;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_branchE     <= 1'b0;
         r_mispredictE <= 1'b0;
      end else begin
         r_branchE     <= w_updateD;
         r_mispredictE <= mispredictD & ~stallD;
      end
   end

`ifdef BPRED_STATS_EN
   logic [31:0] r_brcount;
   logic [31:0] r_mispcount;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_brcount   <= '0;
         r_mispcount <= '0;
      end else if (w_updateD) begin
         r_brcount <= r_brcount + 32'd1;
         if (mispredictD) r_mispcount <= r_mispcount + 32'd1;
      end
   end

   assign brcount   = r_brcount;
   assign mispcount = r_mispcount;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed scenarios followed by random
// traffic, all scored against a behavioural table/pipeline model.
module tb_branch_predict_unit;

   localparam int IDX_W = 6;
   localparam int CNT_W = 2;
   localparam int PC_W  = 32;
   localparam int N     = 1 << IDX_W;
   localparam int CMAX  = (1 << CNT_W) - 1;
   localparam int HALF  = 1 << (CNT_W - 1);

   logic            clk = 1'b0;
   logic            reset;
   logic [PC_W-1:0] pcF;
   logic            predtakenF;
   logic            stallD;
   logic            flushD;
   logic            branchD;
   logic            equalD;
   logic            predtakenD;
   logic            mispredictD;
   logic            recovertakenD;
   logic            branchE;
   logic            mispredictE;
`ifdef BPRED_STATS_EN
   logic [31:0]     brcount;
   logic [31:0]     mispcount;
`endif

   branch_predict_unit #(
      .IDX_W (IDX_W),
      .CNT_W (CNT_W),
      .PC_W  (PC_W)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .pcF           (pcF),
      .predtakenF    (predtakenF),
      .stallD        (stallD),
      .flushD        (flushD),
      .branchD       (branchD),
      .equalD        (equalD),
      .predtakenD    (predtakenD),
      .mispredictD   (mispredictD),
      .recovertakenD (recovertakenD),
      .branchE       (branchE),
      .mispredictE   (mispredictE)
`ifdef BPRED_STATS_EN
      ,
      .brcount       (brcount),
      .mispcount     (mispcount)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: counter values as plain integers plus the in-flight decode slot.
   int          m_cnt [N];
   bit          m_valid;
   bit          m_pred;
   int          m_idx;
   bit          m_brE;
   bit          m_mispE;
   int unsigned m_brc;
   int unsigned m_misc;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
   endtask

   function automatic int f_idx(input logic [31:0] pc);
      return int'((pc / 4) % N);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_cnt[i] = HALF - 1;
      m_valid = 0; m_pred = 0; m_idx = 0;
      m_brE = 0; m_mispE = 0; m_brc = 0; m_misc = 0;
   endtask

   // Drive one cycle of inputs just after the edge, then let them settle.
   task automatic apply(input logic [31:0] pc, input bit br, input bit eq,
                        input bit st, input bit fl, input bit rs);
      pcF = pc; branchD = br; equalD = eq; stallD = st; flushD = fl; reset = rs;
      #3;
   endtask

   // Score the settled outputs, take the clock edge, advance the model.
   task automatic step();
      int fi;
      bit pf, res, misp;
      fi   = f_idx(pcF);
      pf   = (m_cnt[fi] >= HALF);
      res  = branchD && m_valid;
      misp = res && (m_pred != equalD);
      check("predtakenF", predtakenF, pf);
      check("predtakenD", predtakenD, m_pred);
      check("mispredictD", mispredictD, misp);
      check("recovertakenD", recovertakenD, equalD);
      check("branchE", branchE, m_brE);
      check("mispredictE", mispredictE, m_mispE);
`ifdef BPRED_STATS_EN
      check("brcount", brcount, m_brc);
      check("mispcount", mispcount, m_misc);
`endif
      @(posedge clk);
      if (reset) begin
         model_reset();
      end else begin
         if (res && !stallD) begin
            if (equalD) m_cnt[m_idx] = (m_cnt[m_idx] + 1 > CMAX) ? CMAX : m_cnt[m_idx] + 1;
            else        m_cnt[m_idx] = (m_cnt[m_idx] - 1 < 0) ? 0 : m_cnt[m_idx] - 1;
            m_brc++;
            if (misp) m_misc++;
         end
         m_brE   = res && !stallD;
         m_mispE = misp && !stallD;
         if (flushD) begin
            m_valid = 0; m_pred = 0; m_idx = 0;
         end else if (!stallD) begin
            m_valid = 1; m_pred = pf; m_idx = fi;
         end
      end
      #1;
   endtask

   initial begin
      logic [31:0] pc;
      int sel;

      pcF = '0; branchD = 0; equalD = 0; stallD = 0; flushD = 0; reset = 1;
      @(posedge clk);
      #1;
      model_reset();
      apply(32'h40, 0, 0, 0, 0, 1); step();

      // Reset state and the first fetch.
      apply(32'h40, 0, 0, 0, 0, 0);
      check("rst_predF", predtakenF, 0);
      check("rst_cnt16", dut.u_table.r_cnt[16], 1);
      step();

      // Train 0x40 taken: two mispredicts, then a correct taken prediction.
      apply(32'h40, 1, 1, 0, 0, 0);
      check("tr1_misp", mispredictD, 1);
      check("tr1_recov", recovertakenD, 1);
      step();
      apply(32'h40, 1, 1, 0, 0, 0);
      check("tr2_misp", mispredictD, 1);
      check("tr2_predF", predtakenF, 1);
      step();
      apply(32'h40, 1, 1, 0, 0, 0);
      check("tr3_misp", mispredictD, 0);
      step();

      // Saturation at the top, then two decrements.
      repeat (5) begin apply(32'h40, 1, 1, 0, 0, 0); step(); end
      check("sat_hi", dut.u_table.r_cnt[16], 3);
      repeat (2) begin apply(32'h40, 1, 0, 0, 0, 0); step(); end
      check("sat_dn", dut.u_table.r_cnt[16], 1);
      apply(32'h40, 0, 0, 0, 0, 0);
      check("sat_predF", predtakenF, 0);
      step();

      // Stall with a branch in decode: one update, branchE pulses once after release.
      for (int i = 0; i < 3; i++) begin
         apply(32'h40, 1, 1, 1, 0, 0);
         check("stall_brE", branchE, 0);
         step();
      end
      check("stall_cnt", dut.u_table.r_cnt[16], 1);
      apply(32'h40, 1, 1, 0, 0, 0);
      check("rel_brE0", branchE, 0);
      step();
      apply(32'h40, 0, 0, 0, 0, 0);
      check("rel_brE1", branchE, 1);
      check("rel_cnt", dut.u_table.r_cnt[16], 2);
      step();
      apply(32'h40, 0, 0, 0, 0, 0);
      check("rel_brE2", branchE, 0);
      step();

      // Flush beats stall: decode slot empties, a branch there neither mispredicts nor trains.
      apply(32'h40, 0, 0, 1, 1, 0); step();
      apply(32'h40, 1, 1, 0, 0, 0);
      check("flush_misp", mispredictD, 0);
      step();
      check("flush_cnt", dut.u_table.r_cnt[16], 2);

      // Aliasing: 0x140 shares idx 16 with 0x040.
      apply(32'h140, 0, 0, 0, 0, 0);
      check("alias_pred1", predtakenF, 1);
      step();
      apply(32'h040, 1, 0, 0, 0, 0); step();
      apply(32'h140, 0, 0, 0, 0, 0);
      check("alias_pred0", predtakenF, 0);
      step();

      // Random traffic with occasional mid-run reset.
      for (int k = 0; k < 800; k++) begin
         sel = int'($urandom_range(3));
         case (sel)
            0: pc = 32'h40;
            1: pc = 32'h140;
            2: pc = 32'h80;
            default: pc = $urandom;
         endcase
         apply(pc, 1'($urandom_range(1)), 1'($urandom_range(1)),
               $urandom_range(4) == 0, $urandom_range(9) == 0, $urandom_range(149) == 0);
         step();
      end

      apply(32'h0, 0, 0, 0, 0, 0);
      for (int i = 0; i < N; i++) check("table_final", dut.u_table.r_cnt[i], m_cnt[i]);
      step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
